bch_traffic_gen: RTL and testbench

//  Synthesizable, self-checking BCH stimulus engine. LFSR-driven random data and error masks; drives the encoder

---
 rtl/bch_traffic_gen.sv | 217 +++++++++++++++++++++
 tb/tb_bch_traffic_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_traffic_gen.sv
// BCH link-test stimulus engine: LFSR payloads and error masks, encoder handshake, in-flight FIFO, decoder scoring.
// Optional BCH_TRAFFIC_GAP_EN inserts 0-3 LFSR-chosen idle cycles after each encoder handshake.
module bch_traffic_gen #(
  parameter int          DATA_BITS = 5,
  parameter int          CODE_BITS = 15,
  parameter int          T         = 3,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] SEED      = 32'h1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [1:0]             mode_i,
  input  logic [$clog2(T+2)-1:0] nerr_cfg_i,
  input  logic [15:0]            frames_target_i,
  output logic                   enc_valid_o,
  input  logic                   enc_ready_i,
  output logic [DATA_BITS-1:0]   enc_data_o,
  output logic [CODE_BITS-1:0]   err_mask_o,
  input  logic                   dec_valid_i,
  input  logic [DATA_BITS-1:0]   dec_data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   fail_o,
  output logic [15:0]            frame_cnt_o,
  output logic [15:0]            mismatch_cnt_o
);
  localparam int WORDS = (DATA_BITS + 31) / 32;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int NB    = (T > 0) ? $clog2(T + 1) : 1;
  localparam int IB    = (CODE_BITS > 1) ? $clog2(CODE_BITS) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SEED_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY      = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_GEN_DATA, S_GEN_NERR, S_GEN_ERR, S_ISSUE, S_DRAIN, S_DONE
`ifdef BCH_TRAFFIC_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          lfsr_q, lfsr_d, lfsr_step;
  logic [WCW-1:0]       word_q, word_d;
  logic [CODE_BITS-1:0] mask_q, mask_d;
  logic [NB-1:0]        nerr_q, nerr_d, nerr_sel;
  logic [15:0]          frame_cnt_q, frame_cnt_d, mis_q, mis_d;
  logic                 fail_q, fail_d;
  logic [DATA_BITS-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          cnt_q;
  logic                 full, empty, hs, pop, miss, scoring;
  logic [IB-1:0]        idx;
`ifdef BCH_TRAFFIC_GAP_EN
  logic [1:0]           gap_q, gap_d;
`endif

  assign lfsr_step   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
  assign idx         = lfsr_q[IB-1:0];
  assign full        = (cnt_q == (AW+1)'(DEPTH));
  assign empty       = (cnt_q == '0);
  assign enc_valid_o = (state_q == S_ISSUE) && !full;
  assign hs          = enc_valid_o && enc_ready_i;
  assign scoring     = (state_q != S_IDLE);
  assign pop         = scoring && dec_valid_i && !empty;
  // An underflow (empty FIFO) counts as a mismatch without popping.
  assign miss        = scoring && dec_valid_i && (empty || (fifo_mem[rd_q] != dec_data_i));

  // Payload assembled one 32-bit LFSR slice per GEN_DATA cycle.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    localparam int LO = gi * 32;
    localparam int W  = (DATA_BITS - LO < 32) ? (DATA_BITS - LO) : 32;
    logic [W-1:0] slice_q;
    always_ff @(posedge clk_i) begin
      if (!reset_i) slice_q <= '0;
      else if (state_q == S_GEN_DATA && word_q == WCW'(gi)) slice_q <= lfsr_q[W-1:0];
    end
    assign enc_data_o[LO +: W] = slice_q;
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    word_d      = word_q;
    mask_d      = mask_q;
    nerr_d      = nerr_q;
    nerr_sel    = '0;
    frame_cnt_d = frame_cnt_q;
    mis_d       = mis_q;
    fail_d      = fail_q;
`ifdef BCH_TRAFFIC_GAP_EN
    gap_d       = gap_q;
`endif
    case (state_q)
      S_IDLE: if (enable_i) begin
        state_d     = S_GEN_DATA;
        word_d      = '0;
        frame_cnt_d = '0;
        mis_d       = '0;
        fail_d      = 1'b0;
      end
      S_GEN_DATA: begin
        lfsr_d = lfsr_step;
        if (word_q == WCW'(WORDS - 1)) begin
          word_d  = '0;
          state_d = S_GEN_NERR;
        end else begin
          word_d = word_q + 1'b1;
        end
      end
      S_GEN_NERR: begin
        lfsr_d = lfsr_step;
        mask_d = '0;
        case (mode_i)
          2'd0:    nerr_sel = '0;
          2'd1:    nerr_sel = (int'(nerr_cfg_i) > T) ? NB'(T) : NB'(nerr_cfg_i);
          2'd2:    nerr_sel = lfsr_q[NB-1:0];
          default: nerr_sel = NB'(T);
        endcase
        // Random draws above T are rejected by staying here for another draw.
        if (!(mode_i == 2'd2 && int'(nerr_sel) > T)) begin
          nerr_d  = nerr_sel;
          state_d = (nerr_sel == '0) ? S_ISSUE : S_GEN_ERR;
        end
      end
      S_GEN_ERR: begin
        lfsr_d = lfsr_step;
        if (int'(idx) < CODE_BITS && !mask_q[idx]) begin
          mask_d[idx] = 1'b1;
          nerr_d      = nerr_q - 1'b1;
          if (nerr_q == NB'(1)) state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (hs) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        if ((frames_target_i != 16'd0 && frame_cnt_d == frames_target_i) || !enable_i) begin
          state_d = S_DRAIN;
`ifdef BCH_TRAFFIC_GAP_EN
        end else if (lfsr_q[1:0] != 2'd0) begin
          gap_d   = lfsr_q[1:0];
          state_d = S_GAP;
`endif
        end else begin
          state_d = S_GEN_DATA;
        end
      end
`ifdef BCH_TRAFFIC_GAP_EN
      S_GAP: begin
        lfsr_d = lfsr_step;
        gap_d  = gap_q - 2'd1;
        if (gap_q == 2'd1) state_d = S_GEN_DATA;
      end
`endif
      S_DRAIN: if (empty) state_d = S_DONE;
      S_DONE:  if (!enable_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (miss) begin
      fail_d = 1'b1;
      if (mis_q != 16'hFFFF) mis_d = mis_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_INIT;
      word_q      <= '0;
      mask_q      <= '0;
      nerr_q      <= '0;
      frame_cnt_q <= '0;
      mis_q       <= '0;
      fail_q      <= 1'b0;
`ifdef BCH_TRAFFIC_GAP_EN
      gap_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      word_q      <= word_d;
      mask_q      <= mask_d;
      nerr_q      <= nerr_d;
      frame_cnt_q <= frame_cnt_d;
      mis_q       <= mis_d;
      fail_q      <= fail_d;
`ifdef BCH_TRAFFIC_GAP_EN
      gap_q       <= gap_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (hs) fifo_mem[wr_q] <= enc_data_o;
  end

  // Push is only possible when not full, so a pop never makes room for a same-cycle push.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (hs)  wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (hs && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!hs && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign err_mask_o     = mask_q;
  assign busy_o         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o         = (state_q == S_DONE);
  assign fail_o         = fail_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign mismatch_cnt_o = mis_q;
endmodule

// File: tb/tb_bch_traffic_gen.sv
// Bench for bch_traffic_gen: table of runs with loopback decoder plus hand sequences for backpressure and reset.
module tb_bch_traffic_gen;
  localparam int TT = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0, enable = 1'b0, enc_ready = 1'b0, dec_valid = 1'b0;
  logic [1:0]  mode = '0;
  logic [2:0]  nerr_cfg = '0;
  logic [15:0] frames_target = '0;
  logic [4:0]  dec_data = '0;
  logic        enc_valid, busy, done, fail;
  logic [4:0]  enc_data;
  logic [14:0] err_mask;
  logic [15:0] frame_cnt, mismatch_cnt;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_lfsr = 32'h1;

  bch_traffic_gen dut (
    .clk_i(clk), .reset_i(reset_n), .enable_i(enable), .mode_i(mode),
    .nerr_cfg_i(nerr_cfg), .frames_target_i(frames_target),
    .enc_valid_o(enc_valid), .enc_ready_i(enc_ready), .enc_data_o(enc_data),
    .err_mask_o(err_mask), .dec_valid_i(dec_valid), .dec_data_i(dec_data),
    .busy_o(busy), .done_o(done), .fail_o(fail),
    .frame_cnt_o(frame_cnt), .mismatch_cnt_o(mismatch_cnt)
  );

  typedef struct {
    int mode; int ncfg; int target; int corrupt; int drop; int pop; int exp_frames; int exp_mis;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference stream: each generation cycle consumes one value of the Galois LFSR.
  task automatic draw(output logic [31:0] v);
    v = m_lfsr;
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
  endtask

  task automatic model_frame(input int md, input int nc, output logic [4:0] d, output logic [14:0] m);
    logic [31:0] v;
    int n;
    int idx;
    draw(v);
    d = v[4:0];
    draw(v);
    if (md == 0)      n = 0;
    else if (md == 1) n = (nc > TT) ? TT : nc;
    else if (md == 3) n = TT;
    else begin
      n = int'(v % 4);
      while (n > TT) begin draw(v); n = int'(v % 4); end
    end
    m = '0;
    while (n > 0) begin
      draw(v);
      idx = int'(v % 16);
      if (idx < 15 && m[idx] == 1'b0) begin m[idx] = 1'b1; n--; end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_fail"}, {31'd0, fail}, 0);
    check({tag, "_enc_valid"}, {31'd0, enc_valid}, 0);
    check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 0);
    check({tag, "_mismatch_cnt"}, {16'd0, mismatch_cnt}, 0);
    check({tag, "_enc_data"}, {27'd0, enc_data}, 0);
    check({tag, "_err_mask"}, {17'd0, err_mask}, 0);
  endtask

  task automatic run_test(input vec_t t, input bit do_rst, input bit rnd);
    logic        sr_v [3];
    logic [4:0]  sr_d [3];
    logic [4:0]  ed;
    logic [14:0] em;
    logic        rdy, newv;
    logic [4:0]  newd;
    int hs_n = 0;
    int pend = 0;
    bit got_done = 0;
    mode = 2'(t.mode); nerr_cfg = 3'(t.ncfg); frames_target = 16'(t.target);
    enable = 1'b0; enc_ready = 1'b0; dec_valid = 1'b0; dec_data = '0;
    if (do_rst) begin
      reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
    end
    m_lfsr = 32'h1;
    for (int i = 0; i < 3; i++) begin sr_v[i] = 1'b0; sr_d[i] = '0; end
    enable = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (done) begin got_done = 1; break; end
      if (pend > 0) pend++;
      if (pend == 4) enable = 1'b0;
      rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      enc_ready = rdy;
      newv = 1'b0; newd = '0;
      if (enc_valid && rdy) begin
        hs_n++;
        model_frame(t.mode, t.ncfg, ed, em);
        $display("[TB] mode=%0d frame %0d data=%h mask=%h", t.mode, hs_n, enc_data, err_mask);
        check("enc_data", {27'd0, enc_data}, {27'd0, ed});
        check("err_mask", {17'd0, err_mask}, {17'd0, em});
        if (t.pop >= 0) check("popcount", $countones(err_mask), t.pop);
        else            check("popcount_le_T", {31'd0, ($countones(err_mask) <= TT)}, 1);
        newv = 1'b1;
        newd = enc_data ^ ((hs_n == t.corrupt) ? 5'd1 : 5'd0);
        if (t.drop > 0 && hs_n == t.drop) pend = 1;
      end
      dec_valid = sr_v[2]; dec_data = sr_d[2];
      sr_v[2] = sr_v[1]; sr_d[2] = sr_d[1];
      sr_v[1] = sr_v[0]; sr_d[1] = sr_d[0];
      sr_v[0] = newv;    sr_d[0] = newd;
    end
    dec_valid = 1'b0; enc_ready = 1'b0;
    check("done_reached", {31'd0, got_done}, 1);
    check("frame_cnt", {16'd0, frame_cnt}, t.exp_frames);
    check("handshakes", hs_n, t.exp_frames);
    check("mismatch_cnt", {16'd0, mismatch_cnt}, t.exp_mis);
    check("fail", {31'd0, fail}, (t.exp_mis != 0) ? 1 : 0);
    $display("[TB] run mode=%0d target=%0d frames=%0d mismatches=%0d", t.mode, t.target, frame_cnt, mismatch_cnt);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ed;
    logic [14:0] em;
    logic [4:0]  q[$];
    int n;
    int total;
    bit got_done;
    vec_t rep;

    //          mode ncfg target corrupt drop pop frames mis
    vecs[0] = '{0,   0,   8,     0,      0,   0,  8,     0};
    vecs[1] = '{3,   0,   100,   0,      0,   3,  100,   0};
    vecs[2] = '{1,   7,   20,    0,      0,   3,  20,    0};
    vecs[3] = '{1,   2,   12,    0,      0,   2,  12,    0};
    vecs[4] = '{2,   0,   30,    0,      0,   -1, 30,    0};
    vecs[5] = '{0,   0,   5,     2,      0,   0,  5,     1};
    vecs[6] = '{3,   0,   0,     0,      3,   3,  4,     0};

    reset_n = 1'b0; tick(); tick();
    check_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_test(vecs[i], 1'b1, 1'b1);
      if (vecs[i].corrupt != 0) begin
        dec_valid = 1'b1; dec_data = '0;
        tick();
        dec_valid = 1'b0;
        check("spurious_mismatch_cnt", {16'd0, mismatch_cnt}, 2);
        check("spurious_fail", {31'd0, fail}, 1);
        check("spurious_done", {31'd0, done}, 1);
      end
    end

    // Backpressure: decoder silent, FIFO fills at DEPTH frames.
    enable = 1'b0; reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
    m_lfsr = 32'h1; mode = 2'd0; frames_target = 16'd0; enc_ready = 1'b1;
    dec_valid = 1'b0; enable = 1'b1; n = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (enc_valid) begin
        model_frame(0, 0, ed, em);
        check("bp_enc_data", {27'd0, enc_data}, {27'd0, ed});
        q.push_back(ed); n++;
      end
    end
    check("bp_handshakes", n, 4);
    check("bp_enc_valid_low", {31'd0, enc_valid}, 0);
    dec_valid = 1'b1; dec_data = q.pop_front(); n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      dec_valid = 1'b0;
      if (enc_valid) begin
        model_frame(0, 0, ed, em);
        check("bp5_enc_data", {27'd0, enc_data}, {27'd0, ed});
        q.push_back(ed); n++;
      end
    end
    check("bp_fifth_issue", n, 1);
    check("bp_mismatch_cnt", {16'd0, mismatch_cnt}, 0);
    enable = 1'b0; total = 5; got_done = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (done) begin got_done = 1; break; end
      dec_valid = 1'b0;
      if (enc_valid) begin
        model_frame(0, 0, ed, em);
        check("drain_enc_data", {27'd0, enc_data}, {27'd0, ed});
        q.push_back(ed); total++;
      end
      if (c % 2 == 0 && q.size() > 0) begin dec_valid = 1'b1; dec_data = q.pop_front(); end
    end
    dec_valid = 1'b0;
    check("bp_done", {31'd0, got_done}, 1);
    check("bp_frame_cnt", {16'd0, frame_cnt}, 6);
    check("bp_total_handshakes", total, 6);
    check("bp_final_mismatch", {16'd0, mismatch_cnt}, 0);
    $display("[TB] backpressure run frames=%0d", frame_cnt);

    // Reset mid-ISSUE with three frames in flight, then replay from the seed.
    enable = 1'b0; reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
    m_lfsr = 32'h1; mode = 2'd0; frames_target = 16'd0; enc_ready = 1'b1; enable = 1'b1; n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick();
      if (enc_valid) begin
        model_frame(0, 0, ed, em);
        check("rst_enc_data", {27'd0, enc_data}, {27'd0, ed});
        n++;
      end
    end
    tick();
    enc_ready = 1'b0;
    tick(); tick(); tick();
    check("rst_pre_frame_cnt", {16'd0, frame_cnt}, 3);
    check("rst_pre_issue_valid", {31'd0, enc_valid}, 1);
    reset_n = 1'b0; enable = 1'b0;
    tick();
    reset_n = 1'b1;
    check_zero("midrun_reset");
    rep = '{0, 0, 3, 0, 0, 0, 3, 0};
    run_test(rep, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
